// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: imem request/response, redirect,
// decoder-facing output and fault report.
interface fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_inst, out_pc,
    output out_pc_plus4, out_opcode, out_funct3,
    input  out_ready,
    output fault, fault_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_inst, out_pc,
    input  out_pc_plus4, out_opcode, out_funct3,
    output out_ready,
    input  fault, fault_pc
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC, credit-limited imem requests, in-order
// response FIFO, redirect flush and misaligned-target trap.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_BOOT, S_RUN, S_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     head_pc_q, head_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   disc_q, disc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            fault_q, fault_d;
  logic [31:0]     fault_pc_q, fault_pc_d;
  logic [31:0]     mem_q [DEPTH];

  logic [CW-1:0]   live;
  logic [CW:0]     credit;
  logic            req_fire, resp_ok;
  logic            push, pop, redir, misalign;

  // credit uses registered state only; no pop credit
  assign live     = outst_q - disc_q;
  assign credit   = {1'b0, count_q} + {1'b0, live};
  assign bus.imem_req_valid =
    (state_q == S_RUN) && (credit < (CW+1)'(DEPTH));
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  // stray responses after a reset are ignored
  assign resp_ok  = bus.imem_resp_valid && (outst_q != '0);
  assign redir    = bus.redirect_valid && (state_q != S_FAULT);
  assign misalign = |bus.redirect_pc[1:0];
  assign push     = resp_ok && (disc_q == '0) && !redir;
  assign pop      = (count_q != '0) && bus.out_ready && !redir;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    count_d    = count_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(resp_ok);
    disc_d     = disc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase

    if (resp_ok && (disc_q != '0))
      disc_d = disc_q - CW'(1);
    if (req_fire)
      fetch_pc_d = fetch_pc_q + 32'd4;
    if (push)
      wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      head_pc_d = head_pc_q + 32'd4;
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (redir) begin
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = bus.redirect_pc;
      head_pc_d  = bus.redirect_pc;
      disc_d     = outst_d;
      if (misalign) begin
        state_d    = S_FAULT;
        fault_d    = 1'b1;
        fault_pc_d = bus.redirect_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= bus.imem_resp_data;
  end

  assign bus.imem_req_addr = fetch_pc_q;
  assign bus.out_valid     = (count_q != '0);
  assign bus.out_inst      = mem_q[rd_ptr_q];
  assign bus.out_pc        = head_pc_q;
  assign bus.out_pc_plus4  = head_pc_q + 32'd4;
  assign bus.out_opcode    = bus.out_inst[6:0];
  assign bus.out_funct3    = bus.out_inst[14:12];
  assign bus.fault         = fault_q;
  assign bus.fault_pc      = fault_pc_q;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with an in-order
// variable-latency instruction memory model.
module tb_fetch_queue_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if bus();

  fetch_queue_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] inst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    int          cyc;
  } dlv_t;

  req_t mq[$];
  dlv_t dq[$];
  int   cyc = 0;
  int   lat = 1;
  int   max_inflight = 0;
  bit   saw_req = 1'b0;
  int   passed = 0;
  int   total = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'h00C5_8533 ^ {a[24:0], 7'b0};
  endfunction

  // memory model and consumer monitor act on the coming posedge
  always @(negedge clk) begin
    cyc++;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = inst_of(mq[0].addr);
      void'(mq.pop_front());
    end
    if (bus.imem_req_valid) saw_req = 1'b1;
    if (bus.imem_req_valid && bus.imem_req_ready)
      mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
    if (mq.size() > max_inflight) max_inflight = mq.size();
    if (bus.out_valid && bus.out_ready)
      dq.push_back('{pc: bus.out_pc, p4: bus.out_pc_plus4,
                     inst: bus.out_inst, opc: bus.out_opcode,
                     f3: bus.out_funct3, cyc: cyc});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    tick(2);
    mq.delete();
    dq.delete();
    max_inflight = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    lat = 1;
    tick(2);
    mq.delete();
    dq.delete();
    total++;
    if (bus.imem_req_valid !== 1'b0)
      $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid);
    else passed++;
    total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
    else passed++;
    total++;
    if (bus.imem_req_addr !== 32'h0)
      $display("FAIL rst_req_addr: got %h want 0", bus.imem_req_addr);
    else passed++;
    total++;
    if (bus.out_pc !== 32'h0)
      $display("FAIL rst_out_pc: got %h want 0", bus.out_pc);
    else passed++;
    total++;
    if (bus.fault !== 1'b0 || bus.fault_pc !== 32'h0)
      $display("FAIL rst_fault: got %b/%h want 0/0",
               bus.fault, bus.fault_pc);
    else passed++;
    rst = 1'b0;
    total++;
    if (bus.imem_req_valid !== 1'b0)
      $display("FAIL boot_no_req: got %b want 0", bus.imem_req_valid);
    else passed++;
    tick(1);
    total++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0)
      $display("FAIL first_req: got %b/%h want 1/0",
               bus.imem_req_valid, bus.imem_req_addr);
    else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    tick(1);
    total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL lat_early: got %b want 0", bus.out_valid);
    else passed++;
    tick(1);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h00C5_8533 ||
        bus.out_opcode !== 7'h33 || bus.out_funct3 !== 3'd0)
      $display("FAIL first_inst: got %b/%h/%h/%h want 1/00c58533/33/0",
               bus.out_valid, bus.out_inst, bus.out_opcode,
               bus.out_funct3);
    else passed++;
    tick(12);
    total++;
    if (dq.size() < 8)
      $display("FAIL stream_count: got %0d want >=8", dq.size());
    else begin
      passed++;
      for (int i = 0; i < 8; i++) begin
        e = 32'(i * 4);
        total++;
        if (dq[i].pc !== e || dq[i].p4 !== e + 32'd4)
          $display("FAIL stream_pc%0d: got %h/%h want %h/%h",
                   i, dq[i].pc, dq[i].p4, e, e + 32'd4);
        else passed++;
        e = inst_of(e);
        total++;
        if (dq[i].inst !== e || dq[i].f3 !== e[14:12] ||
            dq[i].opc !== e[6:0])
          $display("FAIL stream_inst%0d: got %h want %h",
                   i, dq[i].inst, e);
        else passed++;
        total++;
        if (dq[i].cyc !== dq[0].cyc + i)
          $display("FAIL stream_rate%0d: got cyc %0d want %0d",
                   i, dq[i].cyc, dq[0].cyc + i);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    lat = 1;
    do_reset();
    tick(12);
    total++;
    if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b1 ||
        bus.out_pc !== 32'h0)
      $display("FAIL stall_hold: got %b/%b/%h want 0/1/0",
               bus.imem_req_valid, bus.out_valid, bus.out_pc);
    else passed++;
    total++;
    if (mq.size() != 0 || dq.size() != 0)
      $display("FAIL stall_idle: got inflight %0d out %0d want 0/0",
               mq.size(), dq.size());
    else passed++;
    bus.out_ready = 1'b1;
    bus.imem_req_ready = 1'b0;
    tick(6);
    total++;
    if (dq.size() != 4)
      $display("FAIL stall_drain: got %0d want 4", dq.size());
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (dq[i].pc !== 32'(i * 4) || dq[i].inst !== inst_of(32'(i * 4)))
          $display("FAIL stall_pc%0d: got %h want %h",
                   i, dq[i].pc, 32'(i * 4));
        else passed++;
      end
    end
    tick(2);
    total++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h10)
      $display("FAIL addr_hold: got %b/%h want 1/10",
               bus.imem_req_valid, bus.imem_req_addr);
    else passed++;
    bus.imem_req_ready = 1'b1;
    tick(6);
    total++;
    if (dq.size() < 5 || dq[4].pc !== 32'h10)
      $display("FAIL stall_resume: got n=%0d want pc 10 fifth",
               dq.size());
    else passed++;
    total++;
    if (max_inflight > 4)
      $display("FAIL credit: got %0d inflight want <=4", max_inflight);
    else passed++;
  endtask

  task automatic test_redirect_drop();
    bus.out_ready = 1'b1;
    bus.imem_req_ready = 1'b1;
    lat = 4;
    do_reset();
    tick(4);
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    tick(1);
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 ||
        bus.imem_req_addr !== 32'h100)
      $display("FAIL redir_req: got %b/%b/%h want 0/1/100",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    else passed++;
    dq.delete();
    tick(20);
    total++;
    if (dq.size() < 3)
      $display("FAIL redir_count: got %0d want >=3", dq.size());
    else begin
      passed++;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (dq[i].pc !== 32'h100 + 32'(i * 4) ||
            dq[i].inst !== inst_of(32'h100 + 32'(i * 4)))
          $display("FAIL redir_pc%0d: got %h/%h want %h",
                   i, dq[i].pc, dq[i].inst, 32'h100 + 32'(i * 4));
        else passed++;
      end
    end
  endtask

  task automatic test_redirect_same();
    lat = 1;
    do_reset();
    tick(4);
    total++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hC)
      $display("FAIL same_pre: got %b/%h want 1/c",
               bus.imem_req_valid, bus.imem_req_addr);
    else passed++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    tick(1);
    bus.redirect_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_addr !== 32'h200)
      $display("FAIL same_flush: got %b/%h want 0/200",
               bus.out_valid, bus.imem_req_addr);
    else passed++;
    dq.delete();
    tick(8);
    total++;
    if (dq.size() < 2 || dq[0].pc !== 32'h200 ||
        dq[0].inst !== inst_of(32'h200) || dq[1].pc !== 32'h204)
      $display("FAIL same_first: got n=%0d want pcs 200,204",
               dq.size());
    else passed++;
  endtask

  task automatic test_fault();
    lat = 3;
    do_reset();
    tick(3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h102;
    tick(1);
    bus.redirect_valid = 1'b0;
    total++;
    if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h102)
      $display("FAIL fault_set: got %b/%h want 1/102",
               bus.fault, bus.fault_pc);
    else passed++;
    total++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0)
      $display("FAIL fault_quiet: got %b/%b want 0/0",
               bus.out_valid, bus.imem_req_valid);
    else passed++;
    saw_req = 1'b0;
    dq.delete();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    tick(1);
    bus.redirect_valid = 1'b0;
    tick(8);
    total++;
    if (saw_req !== 1'b0 || dq.size() != 0)
      $display("FAIL fault_stop: got req %b out %0d want 0/0",
               saw_req, dq.size());
    else passed++;
    total++;
    if (bus.fault_pc !== 32'h102 || bus.imem_req_addr !== 32'h102)
      $display("FAIL fault_sticky: got %h/%h want 102/102",
               bus.fault_pc, bus.imem_req_addr);
    else passed++;
    total++;
    if (dut.outst_q !== '0)
      $display("FAIL fault_drain: got %0d want 0", dut.outst_q);
    else passed++;
  endtask

  task automatic test_reset_mid();
    lat = 3;
    do_reset();
    total++;
    if (bus.fault !== 1'b0)
      $display("FAIL fault_clear: got %b want 0", bus.fault);
    else passed++;
    tick(3);
    rst = 1'b1;
    tick(1);
    total++;
    if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.imem_req_addr !== 32'h0 || bus.out_pc !== 32'h0)
      $display("FAIL mid_rst: got %b/%b/%h/%h want 0/0/0/0",
               bus.imem_req_valid, bus.out_valid,
               bus.imem_req_addr, bus.out_pc);
    else passed++;
    mq.delete();
    dq.delete();
    rst = 1'b0;
    tick(1);
    total++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0)
      $display("FAIL mid_restart: got %b/%h want 1/0",
               bus.imem_req_valid, bus.imem_req_addr);
    else passed++;
    tick(10);
    total++;
    if (dq.size() < 2 || dq[0].pc !== 32'h0 ||
        dq[0].inst !== inst_of(32'h0) || dq[1].pc !== 32'h4)
      $display("FAIL mid_stream: got n=%0d want pcs 0,4", dq.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_same();
    test_fault();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
